// File: rtl/button_debounce.sv
// -----------------------------------------------------------------------------
// button_debounce
//
// Debounces one raw push-button pin with the help of an external, non-
// cancellable interval timer. A change of the synchronised button level
// starts one timer interval. The new level is committed only if it held
// for the whole interval. Every output is registered.
//
// Parameters:
//   SYNC_STAGES  synchroniser depth on BTN_IN (2..4)
//   ACTIVE_LOW   1: BTN_IN low means pressed, 0: BTN_IN high means pressed
//
// Ports:
//   CLK          single clock, rising edge
//   RST_N        synchronous active-low reset
//   BTN_IN       raw asynchronous button pin
//   START_TMR    one-cycle request to the timer to start an interval
//   TMR_PULSE    one-cycle end-of-interval pulse from the timer
//   BTN_PRESSED  debounced level, 1 = pressed
//   PRESS        one-cycle strobe when a press is committed
//   RELEASE      one-cycle strobe when a release is committed
// -----------------------------------------------------------------------------
module button_debounce #(
   parameter int SYNC_STAGES = 2,
   parameter bit ACTIVE_LOW  = 1'b1
) (
   input  logic CLK,
   input  logic RST_N,
   input  logic BTN_IN,
   output logic START_TMR,
   input  logic TMR_PULSE,
   output logic BTN_PRESSED,
   output logic PRESS,
   output logic RELEASE
);

   // Pin level that means "not pressed"; the synchroniser resets to it.
   localparam logic IDLE_LVL = ACTIVE_LOW;

   typedef enum logic [1:0] {
      DB_IDLE = 2'b00,
      DB_WAIT = 2'b01
   } db_state_t;

   logic [SYNC_STAGES-1:0] sync_r;
   logic                   btn_sync_s;
   logic                   differ_s;

   db_state_t              state_r;
   db_state_t              next_state_s;

   logic                   unstable_r;
   logic                   start_tmr_r;
   logic                   btn_pressed_r;
   logic                   press_r;
   logic                   release_r;

   logic                   unstable_nxt_s;
   logic                   start_tmr_nxt_s;
   logic                   btn_pressed_nxt_s;
   logic                   press_nxt_s;
   logic                   release_nxt_s;

   // Synchroniser chain for the asynchronous button pin.
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         sync_r <= {SYNC_STAGES{IDLE_LVL}};
      end else begin
         sync_r <= {sync_r[SYNC_STAGES-2:0], BTN_IN};
      end
   end

   // Normalise polarity so that 1 always means pressed.
   assign btn_sync_s = sync_r[SYNC_STAGES-1] ^ ACTIVE_LOW;
   assign differ_s   = (btn_sync_s != btn_pressed_r);

   // State register plus the registered outputs and the bounce flag.
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state_r       <= DB_IDLE;
         unstable_r    <= 1'b0;
         start_tmr_r   <= 1'b0;
         btn_pressed_r <= 1'b0;
         press_r       <= 1'b0;
         release_r     <= 1'b0;
      end else begin
         state_r       <= next_state_s;
         unstable_r    <= unstable_nxt_s;
         start_tmr_r   <= start_tmr_nxt_s;
         btn_pressed_r <= btn_pressed_nxt_s;
         press_r       <= press_nxt_s;
         release_r     <= release_nxt_s;
      end
   end

   // Next-state logic. The timer cannot be cancelled, so DB_WAIT is only
   // ever left on TMR_PULSE, whatever the input does meanwhile.
   always_comb begin
      next_state_s = DB_IDLE;
      case (state_r)
         DB_IDLE: begin
            if (differ_s) begin
               next_state_s = DB_WAIT;
            end else begin
               next_state_s = DB_IDLE;
            end
         end
         DB_WAIT: begin
            if (TMR_PULSE) begin
               next_state_s = DB_IDLE;
            end else begin
               next_state_s = DB_WAIT;
            end
         end
         default: begin
            next_state_s = DB_IDLE;
         end
      endcase
   end

   // Output logic: values loaded into the output registers at the next edge.
   always_comb begin
      unstable_nxt_s    = unstable_r;
      start_tmr_nxt_s   = 1'b0;
      btn_pressed_nxt_s = btn_pressed_r;
      press_nxt_s       = 1'b0;
      release_nxt_s     = 1'b0;
      case (state_r)
         DB_IDLE: begin
            if (differ_s) begin
               start_tmr_nxt_s = 1'b1;
               unstable_nxt_s  = 1'b0;
            end else begin
               start_tmr_nxt_s = 1'b0;
            end
         end
         DB_WAIT: begin
            // Any cycle back at the committed level spoils this interval.
            if (!differ_s) begin
               unstable_nxt_s = 1'b1;
            end else begin
               unstable_nxt_s = unstable_r;
            end
            if (TMR_PULSE && !unstable_r && differ_s) begin
               btn_pressed_nxt_s = btn_sync_s;
               press_nxt_s       = btn_sync_s;
               release_nxt_s     = ~btn_sync_s;
            end else begin
               btn_pressed_nxt_s = btn_pressed_r;
            end
         end
         default: begin
            unstable_nxt_s = 1'b0;
         end
      endcase
   end

   assign START_TMR   = start_tmr_r;
   assign BTN_PRESSED = btn_pressed_r;
   assign PRESS       = press_r;
   assign RELEASE     = release_r;

endmodule

// File: tb/tb_button_debounce.sv
module tb_button_debounce;

   localparam int S = 2;
   localparam int T = 8;

   logic CLK;
   logic RST_N;
   logic BTN_IN;
   logic START_TMR;
   logic TMR_PULSE;
   logic BTN_PRESSED;
   logic PRESS;
   logic RELEASE;

   int n_tests = 0;
   int n_fail  = 0;

   button_debounce #(
      .SYNC_STAGES(S),
      .ACTIVE_LOW (1'b1)
   ) dut (
      .CLK        (CLK),
      .RST_N      (RST_N),
      .BTN_IN     (BTN_IN),
      .START_TMR  (START_TMR),
      .TMR_PULSE  (TMR_PULSE),
      .BTN_PRESSED(BTN_PRESSED),
      .PRESS      (PRESS),
      .RELEASE    (RELEASE)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Timer stand-in: PULSE is sampled by the DUT T edges after START_TMR is sampled.
   logic [3:0] tmr_cnt;
   logic       tmr_pulse_r;
   logic       stray;
   always @(posedge CLK) begin
      if (!RST_N) begin
         tmr_cnt     <= 4'd0;
         tmr_pulse_r <= 1'b0;
      end else begin
         tmr_pulse_r <= (tmr_cnt == 4'd1);
         if (START_TMR) tmr_cnt <= 4'(T - 1);
         else if (tmr_cnt != 4'd0) tmr_cnt <= tmr_cnt - 4'd1;
      end
   end
   assign TMR_PULSE = tmr_pulse_r | stray;

   // Reference model: a history of "pressed" samples per edge; an interval
   // started at edge s ends at edge s+1+T and commits only if the delayed
   // input showed the new level at every edge of the window.
   int  cyc = 16;
   bit  p_hist [0:8191];
   bit  m_level   = 1'b0;
   bit  m_pending = 1'b0;
   bit  m_start   = 1'b0;
   bit  m_press   = 1'b0;
   bit  m_rel     = 1'b0;
   int  m_s       = 0;
   int  m_e       = 0;
   always @(posedge CLK) begin : ref_model
      int now;
      bit ok;
      now = cyc + 1;
      cyc <= now;
      if (!RST_N) begin
         for (int j = now - S + 1; j <= now; j++) p_hist[j] <= 1'b0;
         m_level   <= 1'b0;
         m_pending <= 1'b0;
         m_start   <= 1'b0;
         m_press   <= 1'b0;
         m_rel     <= 1'b0;
      end else begin
         p_hist[now] <= (BTN_IN == 1'b0);
         m_start <= 1'b0;
         m_press <= 1'b0;
         m_rel   <= 1'b0;
         if (m_pending) begin
            if (now == m_e) begin
               ok = 1'b1;
               for (int j = m_s + 1; j <= m_e; j++)
                  if (p_hist[j - S] == m_level) ok = 1'b0;
               if (ok) begin
                  m_level <= ~m_level;
                  m_press <= ~m_level;
                  m_rel   <= m_level;
               end
               m_pending <= 1'b0;
            end
         end else if (p_hist[now - S] != m_level) begin
            m_start   <= 1'b1;
            m_pending <= 1'b1;
            m_s       <= now;
            m_e       <= now + 1 + T;
         end
      end
   end

   task automatic test_reset();
      RST_N  = 1'b0;
      BTN_IN = 1'b1;
      stray  = 1'b0;
      repeat (3) begin
         @(negedge CLK);
         n_tests++;
         if ({START_TMR, BTN_PRESSED, PRESS, RELEASE} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_outputs got=%b exp=0000", {START_TMR, BTN_PRESSED, PRESS, RELEASE});
         end
      end
      RST_N = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge CLK);
         n_tests++;
         if ({START_TMR, BTN_PRESSED, PRESS, RELEASE} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_quiet i=%0d got=%b exp=0000", i, {START_TMR, BTN_PRESSED, PRESS, RELEASE});
         end
      end
   endtask

   task automatic test_clean_press();
      int starts = 0;
      BTN_IN = 1'b0;
      for (int i = 0; i < 16; i++) begin
         @(negedge CLK);
         n_tests++;
         if ({START_TMR, PRESS, RELEASE, BTN_PRESSED} !== {(i == 2), (i == 11), 1'b0, (i >= 11)}) begin
            n_fail++;
            $display("FAIL clean_press i=%0d got=%b exp=%b", i, {START_TMR, PRESS, RELEASE, BTN_PRESSED},
                     {(i == 2), (i == 11), 1'b0, (i >= 11)});
         end
         n_tests++;
         if ({START_TMR, BTN_PRESSED, PRESS, RELEASE} !== {m_start, m_level, m_press, m_rel}) begin
            n_fail++;
            $display("FAIL clean_press_model i=%0d got=%b exp=%b", i, {START_TMR, BTN_PRESSED, PRESS, RELEASE},
                     {m_start, m_level, m_press, m_rel});
         end
         if (START_TMR) starts++;
      end
      n_tests++;
      if (starts !== 1) begin
         n_fail++;
         $display("FAIL clean_press_starts got=%0d exp=1", starts);
      end
   endtask

   task automatic test_release();
      BTN_IN = 1'b1;
      for (int i = 0; i < 16; i++) begin
         @(negedge CLK);
         n_tests++;
         if ({START_TMR, PRESS, RELEASE, BTN_PRESSED} !== {(i == 2), 1'b0, (i == 11), (i < 11)}) begin
            n_fail++;
            $display("FAIL release i=%0d got=%b exp=%b", i, {START_TMR, PRESS, RELEASE, BTN_PRESSED},
                     {(i == 2), 1'b0, (i == 11), (i < 11)});
         end
         n_tests++;
         if ({START_TMR, BTN_PRESSED, PRESS, RELEASE} !== {m_start, m_level, m_press, m_rel}) begin
            n_fail++;
            $display("FAIL release_model i=%0d got=%b exp=%b", i, {START_TMR, BTN_PRESSED, PRESS, RELEASE},
                     {m_start, m_level, m_press, m_rel});
         end
      end
   endtask

   task automatic test_glitch();
      int starts = 0;
      BTN_IN = 1'b0;
      for (int i = 0; i < 26; i++) begin
         @(negedge CLK);
         if (i == 0) BTN_IN = 1'b1;
         n_tests++;
         if ({START_TMR, PRESS, RELEASE, BTN_PRESSED} !== {(i == 2), 3'b000}) begin
            n_fail++;
            $display("FAIL glitch i=%0d got=%b exp=%b", i, {START_TMR, PRESS, RELEASE, BTN_PRESSED}, {(i == 2), 3'b000});
         end
         n_tests++;
         if ({START_TMR, BTN_PRESSED, PRESS, RELEASE} !== {m_start, m_level, m_press, m_rel}) begin
            n_fail++;
            $display("FAIL glitch_model i=%0d got=%b exp=%b", i, {START_TMR, BTN_PRESSED, PRESS, RELEASE},
                     {m_start, m_level, m_press, m_rel});
         end
         if (START_TMR) starts++;
      end
      n_tests++;
      if (starts !== 1) begin
         n_fail++;
         $display("FAIL glitch_starts got=%0d exp=1", starts);
      end
   endtask

   task automatic test_bounce();
      BTN_IN = 1'b0;
      for (int i = 0; i < 26; i++) begin
         @(negedge CLK);
         if (i == 3) BTN_IN = 1'b1;
         if (i == 5) BTN_IN = 1'b0;
         n_tests++;
         if ({START_TMR, PRESS, RELEASE, BTN_PRESSED} !== {(i == 2 || i == 12), (i == 21), 1'b0, (i >= 21)}) begin
            n_fail++;
            $display("FAIL bounce i=%0d got=%b exp=%b", i, {START_TMR, PRESS, RELEASE, BTN_PRESSED},
                     {(i == 2 || i == 12), (i == 21), 1'b0, (i >= 21)});
         end
         n_tests++;
         if ({START_TMR, BTN_PRESSED, PRESS, RELEASE} !== {m_start, m_level, m_press, m_rel}) begin
            n_fail++;
            $display("FAIL bounce_model i=%0d got=%b exp=%b", i, {START_TMR, BTN_PRESSED, PRESS, RELEASE},
                     {m_start, m_level, m_press, m_rel});
         end
      end
   endtask

   task automatic test_reset_mid_wait();
      // Begin a release interval from the pressed state, then reset inside it.
      BTN_IN = 1'b1;
      repeat (6) @(negedge CLK);
      RST_N = 1'b0;
      repeat (2) begin
         @(negedge CLK);
         n_tests++;
         if ({START_TMR, BTN_PRESSED, PRESS, RELEASE} !== 4'b0000) begin
            n_fail++;
            $display("FAIL midwait_reset got=%b exp=0000", {START_TMR, BTN_PRESSED, PRESS, RELEASE});
         end
      end
      RST_N = 1'b1;
      for (int i = 0; i < 24; i++) begin
         @(negedge CLK);
         stray = (i == 5);
         n_tests++;
         if ({START_TMR, BTN_PRESSED, PRESS, RELEASE} !== 4'b0000) begin
            n_fail++;
            $display("FAIL stray_pulse i=%0d got=%b exp=0000", i, {START_TMR, BTN_PRESSED, PRESS, RELEASE});
         end
      end
      BTN_IN = 1'b0;
      for (int i = 0; i < 14; i++) begin
         @(negedge CLK);
         n_tests++;
         if ({START_TMR, PRESS, RELEASE, BTN_PRESSED} !== {(i == 2), (i == 11), 1'b0, (i >= 11)}) begin
            n_fail++;
            $display("FAIL after_reset_press i=%0d got=%b exp=%b", i, {START_TMR, PRESS, RELEASE, BTN_PRESSED},
                     {(i == 2), (i == 11), 1'b0, (i >= 11)});
         end
      end
   endtask

   task automatic test_random();
      int  hold;
      bit  prev_strobe = 1'b0;
      for (int seg = 0; seg < 70; seg++) begin
         BTN_IN = 1'($urandom_range(0, 1));
         hold   = (($urandom_range(0, 2)) == 0) ? $urandom_range(1, 3) : $urandom_range(4, 16);
         if (seg % 23 == 22) RST_N = 1'b0;
         for (int c = 0; c < hold; c++) begin
            @(negedge CLK);
            RST_N = 1'b1;
            n_tests++;
            if ({START_TMR, BTN_PRESSED, PRESS, RELEASE} !== {m_start, m_level, m_press, m_rel}) begin
               n_fail++;
               $display("FAIL random_model seg=%0d got=%b exp=%b", seg, {START_TMR, BTN_PRESSED, PRESS, RELEASE},
                        {m_start, m_level, m_press, m_rel});
            end
            n_tests++;
            if ((PRESS && RELEASE) || (prev_strobe && (PRESS || RELEASE))) begin
               n_fail++;
               $display("FAIL strobe_spacing seg=%0d got=%b%b prev=%b exp=spaced", seg, PRESS, RELEASE, prev_strobe);
            end
            prev_strobe = PRESS | RELEASE;
         end
      end
   endtask

   initial begin
      RST_N  = 1'b0;
      BTN_IN = 1'b1;
      stray  = 1'b0;
      test_reset();
      test_clean_press();
      test_release();
      test_glitch();
      test_bounce();
      test_reset_mid_wait();
      test_release();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
